demux16_skid: RTL and testbench
===============================

DEMUX16_SKID -- requirements
Module: demux16_skid

Interface
REQ-001 Parameter: width, default 16, data bits per transfer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream offers a transfer.
REQ-005 in_ready  output  1  block can accept; registered, never combinationally dependent on out_ready or in_valid.
REQ-006 in_sel  input  4  destination index 0..15, sampled only on accept.
REQ-007 in_data  input  width  payload, sampled only on accept.
REQ-008 out_valid  output  16  per-destination valid; one-hot or all-zero.
REQ-009 out_ready  input  16  per-destination ready.
REQ-010 out_data  output  width  shared payload bus for all destinations, driven from a register.
REQ-011 occupancy  output  2  number of held entries, 0..2.
REQ-012 xfer_count  output  16  count of completed output transfers.

Function
REQ-013 Storage SHALL be a main register (m_valid, m_sel, m_data) and a skid register (s_valid, s_sel, s_data).
REQ-014 in_ready SHALL equal NOT s_valid.
REQ-015 Accept SHALL occur when in_valid AND in_ready on a rising edge.
REQ-016 out_valid[k] SHALL be 1 iff m_valid AND m_sel == k; out_data SHALL equal m_data.
REQ-017 Output fire SHALL occur when m_valid AND out_ready[m_sel]; out_ready bits of non-selected destinations SHALL be ignored.
REQ-018 Main-register update: if main is empty or firing, load from skid if s_valid, else from input if accepting, else clear m_valid; otherwise hold.
REQ-019 Skid update: load from input when accepting while main is full and not firing; clear when its entry moves to main; otherwise hold.
REQ-020 Transfers SHALL leave in strict acceptance order; a stalled destination SHALL block all later transfers (head-of-line), with no reordering.
REQ-021 Latency: an entry accepted into an empty block SHALL appear on out_valid/out_data the next cycle.
REQ-022 Throughput: with the destination ready, one transfer per cycle SHALL be sustained indefinitely.
REQ-023 While out_valid is nonzero and not fired, out_valid, out_data and m_sel SHALL remain stable.
REQ-024 Simultaneous accept and fire with skid empty SHALL load the new entry into main, with no bubble and no skid use.
REQ-025 Simultaneous fire with skid full SHALL move skid to main; in_ready SHALL rise the following cycle.
REQ-026 Full state (occupancy 2): in_ready SHALL be 0, and in_valid SHALL have no effect on state.
REQ-027 occupancy SHALL equal m_valid + s_valid.
REQ-028 xfer_count SHALL increment by 1 on each fire and wrap from 0xFFFF to 0x0000.

Reset
REQ-029 rst_n low SHALL immediately clear m_valid, s_valid, m_sel, s_sel, m_data, s_data and xfer_count, without waiting for a clock edge.
REQ-030 During and after reset: out_valid = 0, out_data = 0, occupancy = 0, xfer_count = 0, in_ready = 1.
REQ-031 Entries held when reset asserts mid-operation SHALL be discarded, never delivered.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Single transfer: after reset, in_sel=5, in_data=0xBEEF for one cycle, out_ready=all 1s -> next cycle out_valid=0x0020, out_data=0xBEEF; following cycle out_valid=0, xfer_count=1.
REQ-034 Backpressure fill: out_ready=0, offer 0x1111 (sel 3), 0x2222 (sel 7), 0x3333 (sel 9) on consecutive cycles -> first two accepted, occupancy=2, in_ready=0, third held; out_valid=0x0008 stable.
REQ-035 Drain ordering: from REQ-034 state, set out_ready[3]=1 only -> 0x1111 fires; then out_valid=0x0080 with 0x2222 and no fire until out_ready[7]=1; 0x3333 is delivered last.
REQ-036 Streaming: 64 back-to-back transfers with sel cycling 0..15 and out_ready=all 1s -> one delivery per cycle, in order, occupancy never exceeds 1, xfer_count=64.
REQ-037 Mid-operation reset: occupancy=2, pulse rst_n low between clock edges -> out_valid=0, occupancy=0 and in_ready=1 immediately; neither held entry is ever delivered.
REQ-038 Wrap: preload 65535 fires, then one more fire -> xfer_count=0x0000.

Source files
------------

// File: rtl/demux16_skid.sv
// demux16_skid -- 1-to-16 demultiplexer with a two-entry skid buffer.
//
// One upstream valid/ready stream is routed to one of 16 destinations
// selected by i_in_sel. A main register drives the outputs. A skid register
// catches one extra entry, so o_in_ready can be a pure register output.
// Delivery is strictly in acceptance order. A stalled destination blocks
// every later entry (head-of-line blocking).
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_in_valid    upstream offers a transfer
//   o_in_ready    block can accept (registered: NOT skid-valid)
//   i_in_sel      destination index, sampled on accept
//   i_in_data     payload, sampled on accept
//   o_out_valid   per-destination valid, one-hot or zero
//   i_out_ready   per-destination ready (only the selected bit matters)
//   o_out_data    shared payload bus, straight from the main register
//   o_occupancy   held entries, 0..2
//   o_xfer_count  completed output transfers, wraps at 16 bits
module demux16_skid #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_in_sel,
    input  logic [WIDTH-1:0] i_in_data,
    output logic [15:0]      o_out_valid,
    input  logic [15:0]      i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_occupancy,
    output logic [15:0]      o_xfer_count
);

    logic             r_m_valid;
    logic [3:0]       r_m_sel;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_valid;
    logic [3:0]       r_s_sel;
    logic [WIDTH-1:0] r_s_data;
    logic [15:0]      r_xfer_count;

    logic w_accept;
    logic w_fire;
    logic w_m_free;

    // The skid entry is the only thing that can block input, so ready is
    // registered state and never looks at i_in_valid or i_out_ready.
    assign o_in_ready = ~r_s_valid;
    assign w_accept   = i_in_valid & ~r_s_valid;
    assign w_fire     = r_m_valid & i_out_ready[r_m_sel];
    // Main can take a new entry this edge: it is empty or it is leaving.
    assign w_m_free   = ~r_m_valid | w_fire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_valid <= 1'b0;
            r_m_sel   <= '0;
            r_m_data  <= '0;
        end else if (w_m_free) begin
            // The skid entry is older than anything on the input, so it wins.
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_sel   <= r_s_sel;
                r_m_data  <= r_s_data;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_sel   <= i_in_sel;
                r_m_data  <= i_in_data;
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_valid <= 1'b0;
            r_s_sel   <= '0;
            r_s_data  <= '0;
        end else if (w_accept && !w_m_free) begin
            r_s_valid <= 1'b1;
            r_s_sel   <= i_in_sel;
            r_s_data  <= i_in_data;
        end else if (r_s_valid && w_m_free) begin
            r_s_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_count <= '0;
        end else if (w_fire) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    // Decode one valid bit per destination.
    for (genvar k = 0; k < 16; k++) begin : g_dec
        assign o_out_valid[k] = r_m_valid & (r_m_sel == 4'(k));
    end

    assign o_out_data   = r_m_data;
    assign o_occupancy  = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_demux16_skid.sv
// Directed bench for demux16_skid. Inputs change 1 ns after the rising edge,
// and outputs are sampled at that same point.
module tb_demux16_skid;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [15:0] in_data;
    logic [15:0] out_valid;
    logic [15:0] out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;

    int nchk = 0;
    int nerr = 0;

    demux16_skid #(.WIDTH(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_sel     (in_sel),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_occupancy  (occupancy),
        .o_xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 4'd0;
        in_data   = 16'h0;
        out_ready = 16'h0;
        #12;
        chk("rst_out_valid", {16'h0, out_valid}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data}, 32'h0);
        chk("rst_occ",       {30'h0, occupancy}, 32'h0);
        chk("rst_xfer",      {16'h0, xfer_count}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready}, 32'h1);
        // Release between edges; the next edge must already accept.
        rst_n = 1'b1;
        #2;

        // Single transfer.
        in_valid = 1'b1; in_sel = 4'd5; in_data = 16'hBEEF; out_ready = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        chk("single_valid", {16'h0, out_valid}, 32'h0020);
        chk("single_data",  {16'h0, out_data}, 32'hBEEF);
        chk("single_occ",   {30'h0, occupancy}, 32'd1);
        tick();
        chk("single_valid_after", {16'h0, out_valid}, 32'h0);
        chk("single_xfer",        {16'h0, xfer_count}, 32'd1);
        chk("single_occ_after",   {30'h0, occupancy}, 32'd0);

        // Backpressure fill.
        out_ready = 16'h0;
        in_valid = 1'b1; in_sel = 4'd3; in_data = 16'h1111;
        tick();
        chk("fill1_occ",   {30'h0, occupancy}, 32'd1);
        chk("fill1_ready", {31'h0, in_ready}, 32'd1);
        in_sel = 4'd7; in_data = 16'h2222;
        tick();
        chk("fill2_occ",   {30'h0, occupancy}, 32'd2);
        chk("fill2_ready", {31'h0, in_ready}, 32'd0);
        in_sel = 4'd9; in_data = 16'h3333;
        tick();
        tick();
        chk("full_occ",   {30'h0, occupancy}, 32'd2);
        chk("full_valid", {16'h0, out_valid}, 32'h0008);
        chk("full_data",  {16'h0, out_data}, 32'h1111);
        chk("full_xfer",  {16'h0, xfer_count}, 32'd1);

        // Drain in order, head-of-line blocking on destination 7.
        out_ready = 16'h0008;
        tick();
        chk("drain1_valid", {16'h0, out_valid}, 32'h0080);
        chk("drain1_data",  {16'h0, out_data}, 32'h2222);
        chk("drain1_xfer",  {16'h0, xfer_count}, 32'd2);
        chk("drain1_ready", {31'h0, in_ready}, 32'd1);
        chk("drain1_occ",   {30'h0, occupancy}, 32'd1);
        tick();   // 0x3333 accepted into skid; dest 7 not ready
        in_valid = 1'b0;
        chk("stall_occ",   {30'h0, occupancy}, 32'd2);
        chk("stall_valid", {16'h0, out_valid}, 32'h0080);
        tick();
        chk("stall_data", {16'h0, out_data}, 32'h2222);
        chk("stall_xfer", {16'h0, xfer_count}, 32'd2);
        out_ready = 16'h0080;
        tick();
        chk("drain2_valid", {16'h0, out_valid}, 32'h0200);
        chk("drain2_data",  {16'h0, out_data}, 32'h3333);
        chk("drain2_xfer",  {16'h0, xfer_count}, 32'd3);
        out_ready = 16'h0200;
        tick();
        chk("drain3_valid", {16'h0, out_valid}, 32'h0);
        chk("drain3_xfer",  {16'h0, xfer_count}, 32'd4);
        chk("drain3_occ",   {30'h0, occupancy}, 32'd0);

        // Streaming: 64 back-to-back transfers.
        out_ready = 16'hFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [15:0] onehot;
            in_sel = 4'(i % 16);
            in_data = 16'hA000 + 16'(i);
            onehot = 16'h1 << (i % 16);
            tick();
            chk($sformatf("stream%0d_valid", i), {16'h0, out_valid}, {16'h0, onehot});
            chk($sformatf("stream%0d_data", i),  {16'h0, out_data}, {16'h0, 16'hA000 + 16'(i)});
            chk($sformatf("stream%0d_occ", i),   {30'h0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_xfer",  {16'h0, xfer_count}, 32'd68);
        chk("stream_valid", {16'h0, out_valid}, 32'h0);

        // Mid-operation reset with two entries held.
        out_ready = 16'h0;
        in_valid = 1'b1; in_sel = 4'd1; in_data = 16'h5555;
        tick();
        in_sel = 4'd2; in_data = 16'h6666;
        tick();
        in_valid = 1'b0;
        chk("prerst_occ", {30'h0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {16'h0, out_valid}, 32'h0);
        chk("midrst_occ",   {30'h0, occupancy}, 32'd0);
        chk("midrst_ready", {31'h0, in_ready}, 32'd1);
        chk("midrst_xfer",  {16'h0, xfer_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst%0d_valid", i), {16'h0, out_valid}, 32'h0);
            chk($sformatf("postrst%0d_xfer", i),  {16'h0, xfer_count}, 32'd0);
        end

        // Wrap: 65535 fires, then one more.
        in_valid = 1'b1; in_sel = 4'd0; in_data = 16'h0;
        repeat (65535) tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_pre_xfer", {16'h0, xfer_count}, 32'hFFFF);
        chk("wrap_pre_occ",  {30'h0, occupancy}, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_xfer", {16'h0, xfer_count}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
